tube_readout_master: RTL and testbench

- Host-side reader for the tube FIFO readout port (16-bit word bus, RD_CLK strobe, RD_EMPTY, RD_VALID).
- Generates RD_CLK strobes and captures words. Filters filler words and decodes each word into tube identity plus drift time.
- Checks each word against the fixed 32-slot event order and presents hits on a valid/ready stream.
- Used for on-board loopback and as the reader for a local event buffer, replacing RPi bit-banging.

---
 rtl/qn_readout_pkg.sv | 30 +++
 rtl/tube_readout_master_sync2.sv | 24 ++
 rtl/tube_readout_master.sv | 188 ++++++++++++++++++
 tb/tb_tube_readout_master.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qn_readout_pkg.sv
// Shared constants, state encoding and field widths for the tube readout master.
// Latency: none; this package holds declarations only.
// Backpressure: not applicable.
package qn_readout_pkg;

  localparam logic [15:0] FILLER_WORD   = 16'hFFFF;
  localparam logic [3:0]  CHAMBER3_CODE = 4'h3;
  localparam logic [3:0]  CHAMBER4_CODE = 4'h4;
  localparam int          SLOTS         = 32;

  localparam int TIME_W  = 8;
  localparam int INDEX_W = 3;
  localparam int SLOT_W  = 5;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CLK_HI     = 3'd1,
    CLK_LO     = 3'd2,
    WAIT_VALID = 3'd3,
    DECODE     = 3'd4,
    PRESENT    = 3'd5
  } state_t;

  // Event position of a tube: chamber 4 occupies slots 16..31, side B the upper 8 of each chamber.
  function automatic logic [SLOT_W-1:0] slot_of(input logic chamber, input logic side,
                                                input logic [INDEX_W-1:0] index);
    return {chamber, side, index};
  endfunction

endpackage

// File: rtl/tube_readout_master_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous level through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tube_readout_master.sv
// Strobes the tube FIFO read port, decodes each word into a hit and checks it against the 32-slot event order.
// Latency: best case one hit per CLK_HI_CYC + CLK_LO_CYC + 4 clk50 cycles (strobe, wait, decode, present).
// Backpressure: while hit_valid waits for hit_ready no new strobe is issued. Option: TUBE_READOUT_SKIP_ZERO_EN drops time-0 hits.
module tube_readout_master
  import qn_readout_pkg::*;
#(
  parameter int CLK_HI_CYC      = 4,
  parameter int CLK_LO_CYC      = 4,
  parameter int VALID_TIMEOUT   = 64,
  parameter int WORDS_PER_EVENT = 32
) (
  input  logic                clk50,
  input  logic                rst_n,
  input  logic                enable,
  output logic                rd_clk,
  output logic                rd_en,
  input  logic                rd_empty,
  input  logic                rd_valid,
  input  logic [15:0]         otube,
  output logic                hit_valid,
  input  logic                hit_ready,
  output logic [TIME_W-1:0]   hit_time,
  output logic                hit_chamber,
  output logic                hit_side,
  output logic [INDEX_W-1:0]  hit_index,
  output logic [SLOT_W-1:0]   hit_slot,
  output logic                event_done,
  output logic [15:0]         event_count,
  output logic                seq_err,
  output logic                timeout_err,
  output logic [7:0]          dup_count
);

  localparam int                CNT_W     = 16;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WORDS_PER_EVENT - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        word_q;
  logic [15:0]        prev_word;
  logic [SLOT_W-1:0]  exp_slot;
  logic               rd_empty_s;
  logic               rd_valid_s;

  logic               dec_ok;
  logic               dec_chamber;
  logic               dec_side;
  logic [INDEX_W-1:0] dec_index;
  logic [SLOT_W-1:0]  dec_slot;

  assign rd_en = enable;

  sync2 u_sync_empty (.clk(clk50), .rst_n(rst_n), .d(rd_empty), .q(rd_empty_s));
  sync2 u_sync_valid (.clk(clk50), .rst_n(rst_n), .d(rd_valid), .q(rd_valid_s));

  // Split the captured name byte into chamber / side / index and the event slot it maps to.
  always_comb begin
    dec_ok      = 1'b0;
    dec_chamber = 1'b0;
    if (word_q[3:0] == CHAMBER3_CODE) begin
      dec_ok = 1'b1;
    end else if (word_q[3:0] == CHAMBER4_CODE) begin
      dec_ok      = 1'b1;
      dec_chamber = 1'b1;
    end
    dec_side  = word_q[4];
    dec_index = word_q[7:5];
    dec_slot  = slot_of(dec_chamber, dec_side, dec_index);
  end

  // Read sequencer: strobe, wait for the latch, decode, then hold the hit until it is taken.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      word_q      <= '0;
      prev_word   <= FILLER_WORD;
      exp_slot    <= '0;
      rd_clk      <= 1'b0;
      hit_valid   <= 1'b0;
      hit_time    <= '0;
      hit_chamber <= 1'b0;
      hit_side    <= 1'b0;
      hit_index   <= '0;
      hit_slot    <= '0;
      event_done  <= 1'b0;
      event_count <= '0;
      seq_err     <= 1'b0;
      timeout_err <= 1'b0;
      dup_count   <= '0;
    end else begin
      event_done  <= 1'b0;
      seq_err     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && !rd_empty_s && !hit_valid) begin
            state  <= CLK_HI;
            rd_clk <= 1'b1;
            cnt    <= '0;
          end
        end
        CLK_HI: begin
          if (cnt == CNT_W'(CLK_HI_CYC - 1)) begin
            state  <= CLK_LO;
            rd_clk <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLK_LO: begin
          if (cnt == CNT_W'(CLK_LO_CYC - 1)) begin
            state <= WAIT_VALID;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_VALID: begin
          // The bus is stable while the valid latch is held, so one capture is enough.
          if (rd_valid_s) begin
            word_q <= otube;
            state  <= DECODE;
          end else if (cnt == CNT_W'(VALID_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DECODE: begin
          if (word_q == FILLER_WORD) begin
            state <= IDLE;
          end else if (!dec_ok) begin
            seq_err <= 1'b1;
            state   <= IDLE;
          end else begin
            // Out-of-order words are still delivered; the expected slot follows the data.
            if (dec_slot != exp_slot) begin
              seq_err  <= 1'b1;
              exp_slot <= dec_slot;
            end
            if ((word_q == prev_word) && (dup_count != 8'hFF)) begin
              dup_count <= dup_count + 1'b1;
            end
            prev_word   <= word_q;
            hit_time    <= word_q[15:8];
            hit_chamber <= dec_chamber;
            hit_side    <= dec_side;
            hit_index   <= dec_index;
            hit_slot    <= dec_slot;
`ifdef TUBE_READOUT_SKIP_ZERO_EN
            // Tube did not fire: account for the slot but do not present it.
            if (word_q[15:8] == '0) begin
              exp_slot <= dec_slot + 1'b1;
              if (dec_slot == LAST_SLOT) begin
                event_done  <= 1'b1;
                event_count <= event_count + 1'b1;
              end
              state <= IDLE;
            end else begin
              hit_valid <= 1'b1;
              state     <= PRESENT;
            end
`else
            hit_valid <= 1'b1;
            state     <= PRESENT;
`endif
          end
        end
        PRESENT: begin
          if (hit_ready) begin
            hit_valid <= 1'b0;
            exp_slot  <= hit_slot + 1'b1;
            if (hit_slot == LAST_SLOT) begin
              event_done  <= 1'b1;
              event_count <= event_count + 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tube_readout_master.sv
// Bench for tube_readout_master: FIFO port model feeding a scoreboard of expected hits.
// Latency: checks strobe/timeout timing in clk50 cycles.
// Backpressure: stalls hit_ready on slot 5 of the second event.
`timescale 1ns/1ps
module tb_tube_readout_master;

  localparam int CLK_HI_CYC    = 4;
  localparam int CLK_LO_CYC    = 4;
  localparam int VALID_TIMEOUT = 64;

  logic        clk50 = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        rd_clk;
  logic        rd_en;
  logic        rd_empty;
  logic        rd_valid = 1'b0;
  logic [15:0] otube = 16'h0000;
  logic        hit_valid;
  logic        hit_ready;
  logic [7:0]  hit_time;
  logic        hit_chamber;
  logic        hit_side;
  logic [2:0]  hit_index;
  logic [4:0]  hit_slot;
  logic        event_done;
  logic [15:0] event_count;
  logic        seq_err;
  logic        timeout_err;
  logic [7:0]  dup_count;

  logic        stall5 = 1'b0;
  logic        no_valid = 1'b0;
  logic [15:0] fifo_q[$];
  logic [17:0] sb_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int seq_cnt  = 0;
  int to_cnt   = 0;
  int done_cnt = 0;
  int hit_cnt  = 0;
  int strobe_cnt = 0;
  logic [4:0] seq_slot = 5'd0;
  logic       prev_rdclk = 1'b0;

  tube_readout_master #(
    .CLK_HI_CYC(CLK_HI_CYC), .CLK_LO_CYC(CLK_LO_CYC),
    .VALID_TIMEOUT(VALID_TIMEOUT), .WORDS_PER_EVENT(32)
  ) dut (
    .clk50(clk50), .rst_n(rst_n), .enable(enable), .rd_clk(rd_clk), .rd_en(rd_en),
    .rd_empty(rd_empty), .rd_valid(rd_valid), .otube(otube),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_time(hit_time),
    .hit_chamber(hit_chamber), .hit_side(hit_side), .hit_index(hit_index),
    .hit_slot(hit_slot), .event_done(event_done), .event_count(event_count),
    .seq_err(seq_err), .timeout_err(timeout_err), .dup_count(dup_count)
  );

  always #10 clk50 = ~clk50;

  assign rd_empty  = (fifo_q.size() == 0);
  assign hit_ready = ~(stall5 & hit_valid & (hit_slot == 5'd5));

  function automatic logic [15:0] word_of(input logic [4:0] s, input logic [7:0] t);
    return {t, s[2:0], s[3], (s[4] ? 4'h4 : 4'h3)};
  endfunction

  function automatic logic [17:0] hit_of(input logic [4:0] s, input logic [7:0] t);
    return {t, s[4], s[3], s[2:0], s};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert = n_assert + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [4:0] s, input logic [7:0] t);
    fifo_q.push_back(word_of(s, t));
    sb_q.push_back(hit_of(s, t));
  endtask

  task automatic run_event();
    for (int s = 0; s < 32; s++) push_word(5'(s), 8'(s + 1));
    fifo_q.push_back(16'hFFFF);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || fifo_q.size() != 0 || hit_valid) && n < 3000) begin
      @(negedge clk50);
      n++;
    end
    check(tag, 32'(n < 3000), 32'd1);
    wait_cyc(30);
  endtask

  // FIFO port model: each rising strobe pops a word onto the bus and raises the valid latch.
  always @(posedge rd_clk) begin
    if (!no_valid && fifo_q.size() != 0) begin
      otube    = fifo_q.pop_front();
      rd_valid = 1'b1;
    end else begin
      rd_valid = 1'b0;
    end
  end

  // Output monitor: scoreboard compare on every accepted hit, plus pulse counters.
  always @(negedge clk50) begin
    if (rd_clk && !prev_rdclk) strobe_cnt = strobe_cnt + 1;
    prev_rdclk = rd_clk;
    if (rst_n) begin
      if (seq_err) begin
        seq_cnt  = seq_cnt + 1;
        seq_slot = hit_slot;
      end
      if (timeout_err) to_cnt = to_cnt + 1;
      if (event_done) done_cnt = done_cnt + 1;
      if (hit_valid && hit_ready) begin
        hit_cnt = hit_cnt + 1;
        if (sb_q.size() == 0) begin
          check("hit_unexpected", 32'd1, 32'd0);
        end else begin
          check("hit_fields", 32'({hit_time, hit_chamber, hit_side, hit_index, hit_slot}),
                32'(sb_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int s0;
    logic [17:0] snap;
    logic ok;

    // Reset state
    wait_cyc(3);
    check("rst_rd_clk", 32'(rd_clk), 32'd0);
    check("rst_hit_valid", 32'(hit_valid), 32'd0);
    check("rst_event_count", 32'(event_count), 32'd0);
    check("rst_dup_count", 32'(dup_count), 32'd0);
    check("rst_pulses", 32'({seq_err, timeout_err, event_done}), 32'd0);
    check("rst_hit_fields", 32'({hit_time, hit_chamber, hit_side, hit_index, hit_slot}), 32'd0);
    rst_n = 1'b1;
    wait_cyc(2);
    check("rd_en_low", 32'(rd_en), 32'd0);

    // One full event, consumer always ready
    run_event();
    enable = 1'b1;
    #1;
    check("rd_en_high", 32'(rd_en), 32'd1);
    wait_drain("ev1_drain");
    check("ev1_hits", 32'(hit_cnt), 32'd32);
    check("ev1_done", 32'(done_cnt), 32'd1);
    check("ev1_event_count", 32'(event_count), 32'd1);
    check("ev1_seq_err", 32'(seq_cnt), 32'd0);
    check("ev1_timeout", 32'(to_cnt), 32'd0);
    check("ev1_dup", 32'(dup_count), 32'd0);

    // Second event with a 50-cycle stall on slot 5
    stall5 = 1'b1;
    run_event();
    n = 0;
    while (!(hit_valid && hit_slot == 5'd5) && n < 2000) begin
      @(negedge clk50);
      n++;
    end
    check("bp_reach_slot5", 32'(n < 2000), 32'd1);
    snap = {hit_time, hit_chamber, hit_side, hit_index, hit_slot};
    check("bp_slot5_time", 32'(hit_time), 32'd6);
    s0 = strobe_cnt;
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk50);
      if ({hit_time, hit_chamber, hit_side, hit_index, hit_slot} !== snap ||
          rd_clk !== 1'b0 || hit_valid !== 1'b1) ok = 1'b0;
    end
    check("bp_stable", 32'(ok), 32'd1);
    check("bp_no_strobe", 32'(strobe_cnt), 32'(s0));
    @(posedge clk50);
    #1 stall5 = 1'b0;
    n = 0;
    @(negedge clk50);
    while (!(hit_valid && hit_slot != 5'd5) && n < 200) begin
      @(negedge clk50);
      n++;
    end
    check("bp_next_slot", 32'(hit_slot), 32'd6);
    wait_drain("ev2_drain");
    check("ev2_hits", 32'(hit_cnt), 32'd64);
    check("ev2_done", 32'(done_cnt), 32'd2);
    check("ev2_event_count", 32'(event_count), 32'd2);
    check("ev2_seq_err", 32'(seq_cnt), 32'd0);

    // Same word twice: second copy is a duplicate and out of order
    push_word(5'd0, 8'h12);
    push_word(5'd0, 8'h12);
    wait_drain("dup_drain");
    check("dup_count", 32'(dup_count), 32'd1);
    check("dup_seq_err", 32'(seq_cnt), 32'd1);
    check("dup_seq_slot", 32'(seq_slot), 32'd0);

    // Reset while the strobe is high
    no_valid = 1'b1;
    fifo_q.push_back(word_of(5'd0, 8'h77));
    n = 0;
    while (rd_clk !== 1'b1 && n < 100) begin
      @(negedge clk50);
      n++;
    end
    check("rst_strobe_seen", 32'(n < 100), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_async_rd_clk", 32'(rd_clk), 32'd0);
    enable = 1'b0;
    check("rst_mid_event_count", 32'(event_count), 32'd0);
    check("rst_mid_dup_count", 32'(dup_count), 32'd0);
    check("rst_mid_hit_valid", 32'(hit_valid), 32'd0);
    wait_cyc(2);
    @(posedge clk50);
    #1 rst_n = 1'b1;
    s0 = strobe_cnt;
    wait_cyc(6);
    check("rst_idle_no_strobe", 32'({rd_clk, hit_valid}), 32'd0);
    check("rst_idle_strobe_cnt", 32'(strobe_cnt), 32'(s0));

    // Order violation: slot 0, slot 3, then slot 4 in step
    no_valid = 1'b0;
    sb_q.push_back(hit_of(5'd0, 8'h77));
    push_word(5'd3, 8'h0A);
    push_word(5'd4, 8'h0B);
    check("order_word", 32'(word_of(5'd3, 8'h0A)), 32'h0A63);
    s0 = seq_cnt;
    enable = 1'b1;
    wait_drain("order_drain");
    check("order_seq_err", 32'(seq_cnt - s0), 32'd1);
    check("order_seq_slot", 32'(seq_slot), 32'd3);

    // Missing valid: timeout after VALID_TIMEOUT cycles in WAIT_VALID, then a retry
    no_valid = 1'b1;
    push_word(5'd5, 8'h55);
    s0 = to_cnt;
    n = 0;
    while (rd_clk !== 1'b1 && n < 100) begin
      @(negedge clk50);
      n++;
    end
    n = 0;
    while (rd_clk !== 1'b0 && n < 100) begin
      @(negedge clk50);
      n++;
    end
    n = 0;
    while (timeout_err !== 1'b1 && n < 300) begin
      @(negedge clk50);
      n++;
    end
    check("timeout_latency", 32'(n), 32'(CLK_LO_CYC + VALID_TIMEOUT));
    no_valid = 1'b0;
    n = 0;
    while (rd_clk !== 1'b1 && n < 6) begin
      @(negedge clk50);
      n++;
    end
    check("timeout_retry", 32'(rd_clk), 32'd1);
    wait_drain("timeout_drain");
    check("timeout_count", 32'(to_cnt - s0), 32'd1);
    check("timeout_hits", 32'(hit_cnt), 32'd70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
